// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for the shared-bus datapath (fetch, decode, execute, memory watchdog).
// Optional single-instruction stepping is enabled by defining DATAPATH_SEQ_STEP_EN.
module datapath_sequencer #(
   parameter int         MEM_TIMEOUT = 15,
   parameter logic [4:0] ALU_ADD     = 5'b00011,
   parameter logic [4:0] ALU_AND     = 5'b00101,
   parameter logic [4:0] ALU_OR      = 5'b00110
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        run,
`ifdef DATAPATH_SEQ_STEP_EN
   input  logic        step,
`endif
   input  logic [31:0] ir,
   input  logic        mem_ready,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        IRin,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        MDRread,
   output logic        MEMwrite,
   output logic        Yin,
   output logic        Zlowin,
   output logic        Zhighin,
   output logic        ZLowout,
   output logic        ZHighout,
   output logic        HIin,
   output logic        LOin,
   output logic        Cout,
   output logic [4:0]  ALUselect,
   output logic        halted,
   output logic        fault
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_T0    = 4'd1;
   localparam logic [3:0] S_T1    = 4'd2;
   localparam logic [3:0] S_T2    = 4'd3;
   localparam logic [3:0] S_T3    = 4'd4;
   localparam logic [3:0] S_T4    = 4'd5;
   localparam logic [3:0] S_T5    = 4'd6;
   localparam logic [3:0] S_T6    = 4'd7;
   localparam logic [3:0] S_T7    = 4'd8;
   localparam logic [3:0] S_HALT  = 4'd9;
   localparam logic [3:0] S_FAULT = 4'd10;

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   logic [3:0]    state, state_next;
   logic [CW-1:0] wait_cnt, wait_cnt_next;
   logic          go, in_wait, timeout;
   logic [3:0]    done_next;

   wire [4:0]  opcode = ir[31:27];
   wire [15:0] ra_hot = 16'h0001 << ir[26:23];
   wire [15:0] rb_hot = 16'h0001 << ir[22:19];
   wire [15:0] rc_hot = 16'h0001 << ir[18:15];
   logic       unused_ir;
   assign unused_ir = ^ir[14:0];

   wire is_rtype  = (opcode >= 5'b00011) && (opcode <= 5'b01011);
   wire is_imm    = (opcode >= 5'b01100) && (opcode <= 5'b01110);
   wire is_muldiv = (opcode == 5'b01111) || (opcode == 5'b10000);
   wire is_ld     = (opcode == 5'b00000);
   wire is_ldi    = (opcode == 5'b00001);
   wire is_st     = (opcode == 5'b00010);
   wire is_nop    = (opcode == 5'b11010);
   wire is_halt   = (opcode == 5'b11011);
   wire is_legal  = is_rtype | is_imm | is_muldiv | is_ld | is_ldi | is_st | is_nop | is_halt;

`ifdef DATAPATH_SEQ_STEP_EN
   logic step_q;
   always_ff @(posedge clk) begin
      if (clr) step_q <= 1'b0;
      else     step_q <= step;
   end
   assign go = run & step & ~step_q;
`else
   assign go = run;
`endif

   assign done_next = go ? S_T0 : S_IDLE;
   assign in_wait   = (state == S_T1) || (state == S_T6 && is_ld) || (state == S_T7 && is_st);
   assign timeout   = (wait_cnt == CW'(MEM_TIMEOUT - 1));

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_next    = state;
      wait_cnt_next = '0;
      case (state)
         S_IDLE:  if (go) state_next = S_T0;
         S_T0:    state_next = S_T1;
         S_T1:    state_next = S_T2;
         S_T2:    state_next = S_T3;
         S_T3: begin
            if (!is_legal)    state_next = S_FAULT;
            else if (is_halt) state_next = S_HALT;
            else if (is_nop)  state_next = done_next;
            else              state_next = S_T4;
         end
         S_T4:    state_next = S_T5;
         S_T5:    state_next = (is_ld || is_st || is_muldiv) ? S_T6 : done_next;
         S_T6:    state_next = is_muldiv ? done_next : S_T7;
         S_T7:    state_next = done_next;
         default: state_next = state;
      endcase
      // A wait state without mem_ready either stays and counts, or trips the watchdog.
      if (in_wait && !mem_ready) begin
         if (timeout) begin
            state_next = S_FAULT;
         end else begin
            state_next    = state;
            wait_cnt_next = wait_cnt + CW'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; clr is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         fault    <= 1'b0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
         fault    <= fault | (state_next == S_FAULT);
      end
   end

   // Strobes decode the state register and the IR register, so they only move on clock edges.
   always_comb begin
      Rin = '0;  Rout = '0;  ALUselect = '0;
      PCout = 1'b0;  PCin = 1'b0;  IncPC = 1'b0;  IRin = 1'b0;  MARin = 1'b0;
      MDRin = 1'b0;  MDRout = 1'b0;  MDRread = 1'b0;  MEMwrite = 1'b0;
      Yin = 1'b0;  Zlowin = 1'b0;  Zhighin = 1'b0;  ZLowout = 1'b0;  ZHighout = 1'b0;
      HIin = 1'b0;  LOin = 1'b0;  Cout = 1'b0;
      case (state)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
         S_T1: begin MDRread = 1'b1; MDRin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3: begin
            if (is_muldiv) begin
               Rout = ra_hot; Yin = 1'b1;
            end else if (is_rtype || is_imm || is_ldi || is_ld || is_st) begin
               Rout = rb_hot; Yin = 1'b1;
            end
         end
         S_T4: begin
            Zlowin = 1'b1;
            if (is_rtype) begin
               Rout = rc_hot; Zhighin = 1'b1; ALUselect = opcode;
            end else if (is_imm) begin
               Cout = 1'b1; Zhighin = 1'b1;
               ALUselect = (opcode == 5'b01100) ? ALU_ADD :
                           (opcode == 5'b01101) ? ALU_AND : ALU_OR;
            end else if (is_muldiv) begin
               Rout = rb_hot; Zhighin = 1'b1; ALUselect = opcode;
            end else begin
               Cout = 1'b1; ALUselect = ALU_ADD;
            end
         end
         S_T5: begin
            ZLowout = 1'b1;
            if (is_muldiv)          LOin  = 1'b1;
            else if (is_ld || is_st) MARin = 1'b1;
            else                    Rin   = ra_hot;
         end
         S_T6: begin
            if (is_muldiv) begin
               ZHighout = 1'b1; HIin = 1'b1;
            end else if (is_ld) begin
               MDRread = 1'b1; MDRin = 1'b1;
            end else if (is_st) begin
               Rout = ra_hot; MDRin = 1'b1;
            end
         end
         S_T7: begin
            if (is_ld) begin
               MDRout = 1'b1; Rin = ra_hot;
            end else if (is_st) begin
               MEMwrite = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign halted = (state == S_HALT);

endmodule
